// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state codes,
// redirect-select encoding and inter-stage register indices.
package pipe_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN      = 2'd0;
    localparam state_t ST_MEM_WAIT = 2'd1;
    localparam state_t ST_MDU_WAIT = 2'd2;

    localparam logic [1:0] RD_NONE   = 2'd0;
    localparam logic [1:0] RD_BRANCH = 2'd1;
    localparam logic [1:0] RD_EXC    = 2'd2;

    localparam int R_IFID  = 0;
    localparam int R_IDEX  = 1;
    localparam int R_EXMEM = 2;
    localparam int R_MEMWB = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-event inputs and stall/flush/redirect outputs of the hazard controller.
// master = pipeline side raising events, slave = the controller.
interface pipe_hazard_ctrl_if #(
    parameter int NREG = 4,
    parameter int CW   = 32
);
    logic            load_use;
    logic            mdu_start;
    logic            dcache_miss;
    logic            dcache_ready;
    logic            br_mispredict;
    logic            exception;
    logic            pc_stall;
    logic [NREG-1:0] stall;
    logic [NREG-1:0] flush;
    logic [1:0]      redirect_sel;
    logic            busy;
    logic            hang;
    logic [CW-1:0]   stall_cycles;

    modport master (
        output load_use, mdu_start, dcache_miss, dcache_ready, br_mispredict, exception,
        input  pc_stall, stall, flush, redirect_sel, busy, hang, stall_cycles
    );

    modport slave (
        input  load_use, mdu_start, dcache_miss, dcache_ready, br_mispredict, exception,
        output pc_stall, stall, flush, redirect_sel, busy, hang, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage in-order pipeline: priority
// hazard resolution, miss/MDU wait FSM, hang watchdog and stall counter.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int NREG    = 4,
    parameter int MDU_LAT = 4,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int MCW = $clog2(MDU_LAT) + 1;
    localparam int WDW = $clog2(TIMEOUT) + 1;
    localparam logic [MCW-1:0] MDU_LOAD = MCW'(MDU_LAT - 1);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);

    typedef struct packed {
        logic            pc_stall;
        logic [NREG-1:0] stall;
        logic [NREG-1:0] flush;
        logic [1:0]      redir;
        state_t          nxt;
        logic            mdu_load;
    } eval_t;

    state_t         state_q, state_d;
    logic [MCW-1:0] mdu_cnt_q, mdu_cnt_d;
    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
    logic           hang_q, hang_d;
    logic [CW-1:0]  stall_cycles_q, stall_cycles_d;
    eval_t          ev;
    logic           busy;

    // Strict-priority RUN evaluation; release cycles reuse it with masked events.
    function automatic eval_t eval_run(
        input logic exc,
        input logic miss,
        input logic br,
        input logic mdu,
        input logic lu
    );
        eval_t r;
        r     = '0;
        r.nxt = ST_RUN;
        if (exc) begin
            r.flush[R_IFID]  = 1'b1;
            r.flush[R_IDEX]  = 1'b1;
            r.flush[R_EXMEM] = 1'b1;
            r.flush[R_MEMWB] = 1'b1;
            r.redir          = RD_EXC;
        end else if (miss) begin
            r.pc_stall       = 1'b1;
            r.stall[R_IFID]  = 1'b1;
            r.stall[R_IDEX]  = 1'b1;
            r.stall[R_EXMEM] = 1'b1;
            r.flush[R_MEMWB] = 1'b1;
            r.nxt            = ST_MEM_WAIT;
        end else if (br) begin
            r.flush[R_IFID]  = 1'b1;
            r.flush[R_IDEX]  = 1'b1;
            r.redir          = RD_BRANCH;
        end else if (mdu) begin
            r.pc_stall       = 1'b1;
            r.stall[R_IFID]  = 1'b1;
            r.stall[R_IDEX]  = 1'b1;
            r.flush[R_EXMEM] = 1'b1;
            r.nxt            = ST_MDU_WAIT;
            r.mdu_load       = 1'b1;
        end else if (lu) begin
            r.pc_stall       = 1'b1;
            r.stall[R_IFID]  = 1'b1;
            r.flush[R_IDEX]  = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        ev     = '0;
        ev.nxt = ST_RUN;
        case (state_q)
            ST_RUN: begin
                ev = eval_run(hz.exception, hz.dcache_miss, hz.br_mispredict,
                              hz.mdu_start, hz.load_use);
            end
            ST_MEM_WAIT: begin
                if (!hz.dcache_ready) begin
                    ev     = eval_run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                    ev.nxt = ST_MEM_WAIT;
                end else begin
                    ev = eval_run(1'b0, 1'b0, hz.br_mispredict, hz.mdu_start, hz.load_use);
                end
            end
            ST_MDU_WAIT: begin
                if (mdu_cnt_q != '0) begin
                    ev          = eval_run(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                    ev.nxt      = ST_MDU_WAIT;
                    ev.mdu_load = 1'b0;
                end else begin
                    ev = eval_run(hz.exception, hz.dcache_miss, hz.br_mispredict,
                                  1'b0, hz.load_use);
                end
            end
            default: begin
                ev     = '0;
                ev.nxt = ST_RUN;
            end
        endcase
    end

    assign busy = (state_q != ST_RUN);

    always_comb begin
        state_d = ev.nxt;

        mdu_cnt_d = mdu_cnt_q;
        if (ev.mdu_load) begin
            mdu_cnt_d = MDU_LOAD;
        end else if (state_q == ST_MDU_WAIT && mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - MCW'(1);
        end

        // Saturate so a long hang never wraps the watchdog back below its trip point.
        wd_cnt_d = '0;
        if (busy) begin
            wd_cnt_d = (wd_cnt_q == WD_LAST) ? wd_cnt_q : wd_cnt_q + WDW'(1);
        end

        hang_d = hang_q | (busy && wd_cnt_q == WD_LAST);

        stall_cycles_d = ev.pc_stall ? stall_cycles_q + CW'(1) : stall_cycles_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            mdu_cnt_q      <= '0;
            wd_cnt_q       <= '0;
            hang_q         <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            mdu_cnt_q      <= mdu_cnt_d;
            wd_cnt_q       <= wd_cnt_d;
            hang_q         <= hang_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Everything is forced quiet while reset is held, including registered outputs.
    assign hz.pc_stall     = rst ? 1'b0 : ev.pc_stall;
    assign hz.stall        = rst ? '0 : ev.stall;
    assign hz.flush        = rst ? '0 : ev.flush;
    assign hz.redirect_sel = rst ? RD_NONE : ev.redir;
    assign hz.busy         = rst ? 1'b0 : busy;
    assign hz.hang         = rst ? 1'b0 : hang_q;
    assign hz.stall_cycles = rst ? '0 : stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    localparam logic [5:0] E_LU   = 6'b000001;
    localparam logic [5:0] E_MDU  = 6'b000010;
    localparam logic [5:0] E_MISS = 6'b000100;
    localparam logic [5:0] E_RDY  = 6'b001000;
    localparam logic [5:0] E_BR   = 6'b010000;
    localparam logic [5:0] E_EXC  = 6'b100000;

    typedef struct {
        string      nm;
        logic       pc;
        logic [3:0] st;
        logic [3:0] fl;
        logic [1:0] rd;
        logic       bz;
        logic       hg;
        int         sc;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sbq[$];
    int   n_cmp;
    int   n_err;

    pipe_hazard_ctrl_if #(.NREG(4), .CW(32)) hz ();

    pipe_hazard_ctrl #(
        .NREG(4), .MDU_LAT(4), .TIMEOUT(8), .CW(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string f, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s %s: got %0h, expected %0h", nm, f, got, want);
        end
    endtask

    task automatic step(input string nm, input logic r, input logic [5:0] e,
                        input logic pc, input logic [3:0] st, input logic [3:0] fl,
                        input logic [1:0] rd, input logic bz, input logic hg,
                        input int sc);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r;
        {hz.exception, hz.br_mispredict, hz.dcache_ready,
         hz.dcache_miss, hz.mdu_start, hz.load_use} = e;
        x.nm = nm; x.pc = pc; x.st = st; x.fl = fl; x.rd = rd;
        x.bz = bz; x.hg = hg; x.sc = sc;
        sbq.push_back(x);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t x;
            x = sbq.pop_front();
            chk(x.nm, "pc_stall", 32'(hz.pc_stall), 32'(x.pc));
            chk(x.nm, "stall", 32'(hz.stall), 32'(x.st));
            chk(x.nm, "flush", 32'(hz.flush), 32'(x.fl));
            chk(x.nm, "redirect_sel", 32'(hz.redirect_sel), 32'(x.rd));
            chk(x.nm, "busy", 32'(hz.busy), 32'(x.bz));
            chk(x.nm, "hang", 32'(hz.hang), 32'(x.hg));
            if (x.sc >= 0) chk(x.nm, "stall_cycles", hz.stall_cycles, 32'(x.sc));
        end
    end

    initial begin
        int budget;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        {hz.exception, hz.br_mispredict, hz.dcache_ready,
         hz.dcache_miss, hz.mdu_start, hz.load_use} = '0;

        //     name       rst  events          pc  stall    flush    rd  bz hg  sc
        step("rst_a",    1, E_LU | E_MISS,   0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        step("rst_b",    1, 6'd0,            0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        step("idle",     0, 6'd0,            0, 4'b0000, 4'b0000, 0, 0, 0, 0);

        step("lu",       0, E_LU,            1, 4'b0001, 4'b0010, 0, 0, 0, 0);
        step("lu_after", 0, 6'd0,            0, 4'b0000, 4'b0000, 0, 0, 0, 1);

        step("br_lu",    0, E_BR | E_LU,     0, 4'b0000, 4'b0011, 1, 0, 0, 1);
        step("br_after", 0, 6'd0,            0, 4'b0000, 4'b0000, 0, 0, 0, 1);

        step("miss0",    0, E_MISS,          1, 4'b0111, 4'b1000, 0, 0, 0, 1);
        step("miss1",    0, E_MISS | E_BR,   1, 4'b0111, 4'b1000, 0, 1, 0, 2);
        step("miss2",    0, 6'd0,            1, 4'b0111, 4'b1000, 0, 1, 0, 3);
        step("miss_rel", 0, E_RDY,           0, 4'b0000, 4'b0000, 0, 1, 0, 4);
        step("miss_run", 0, 6'd0,            0, 4'b0000, 4'b0000, 0, 0, 0, 4);

        step("mdu0",     0, E_MDU,           1, 4'b0011, 4'b0100, 0, 0, 0, 4);
        step("mdu1",     0, E_MDU,           1, 4'b0011, 4'b0100, 0, 1, 0, 5);
        step("mdu2",     0, E_MDU,           1, 4'b0011, 4'b0100, 0, 1, 0, 6);
        step("mdu3",     0, E_MDU,           1, 4'b0011, 4'b0100, 0, 1, 0, 7);
        step("mdu_rel",  0, E_MDU,           0, 4'b0000, 4'b0000, 0, 1, 0, 8);
        step("mdu_run",  0, 6'd0,            0, 4'b0000, 4'b0000, 0, 0, 0, 8);

        step("miss_exc", 0, E_MISS | E_EXC,  0, 4'b0000, 4'b1111, 2, 0, 0, 8);
        step("exc_run",  0, 6'd0,            0, 4'b0000, 4'b0000, 0, 0, 0, 8);

        step("mb_miss",  0, E_MISS,          1, 4'b0111, 4'b1000, 0, 0, 0, 8);
        step("mb_rel",   0, E_RDY | E_BR | E_EXC, 0, 4'b0000, 4'b0011, 1, 1, 0, 9);
        step("mb_run",   0, 6'd0,            0, 4'b0000, 4'b0000, 0, 0, 0, 9);

        step("wd_miss",  0, E_MISS,          1, 4'b0111, 4'b1000, 0, 0, 0, 9);
        for (int i = 0; i < 9; i++) begin
            step($sformatf("wd_wait%0d", i), 0, 6'd0, 1, 4'b0111, 4'b1000, 0, 1,
                 (i == 8) ? 1'b1 : 1'b0, 10 + i);
        end
        step("wd_rel",   0, E_RDY,           0, 4'b0000, 4'b0000, 0, 1, 1, 19);
        step("wd_run",   0, 6'd0,            0, 4'b0000, 4'b0000, 0, 0, 1, 19);
        step("wd_rst",   1, E_MISS,          0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        step("wd_clr",   0, 6'd0,            0, 4'b0000, 4'b0000, 0, 0, 0, 0);

        step("ab_miss",  0, E_MISS,          1, 4'b0111, 4'b1000, 0, 0, 0, 0);
        step("ab_rst",   1, 6'd0,            0, 4'b0000, 4'b0000, 0, 0, 0, 0);
        step("ab_run",   0, 6'd0,            0, 4'b0000, 4'b0000, 0, 0, 0, 0);

        budget = 20;
        while (sbq.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (sbq.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage in-order pipeline (IF, ID, EX, MEM, WB). Collects hazard and redirect events from ID, EX and MEM. Drives the per-register stall and flush inputs of the four inter-stage pipeline registers plus the PC stall and redirect select. Contains a small FSM, a multi-cycle-unit countdown, a hang watchdog and a stall performance counter.

Parameters:
NREG, 4, number of inter-stage registers; index 0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB
MDU_LAT, 4, fixed mul/div latency in stall cycles (>=1)
TIMEOUT, 1024, consecutive non-RUN cycles before hang is flagged
CW, 32, width of stall_cycles counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
load_use  in  1  ID instr depends on load currently in EX
mdu_start  in  1  EX holds mul/div op
dcache_miss  in  1  MEM load/store missed
dcache_ready  in  1  miss data returned this cycle
br_mispredict  in  1  EX branch resolved mispredicted
exception  in  1  MEM instr raises exception
pc_stall  out  1  hold PC
stall  out  NREG  per-register hold
flush  out  NREG  per-register clear (flush overrides stall at the register)
redirect_sel  out  2  0 none, 1 branch target, 2 exception vector
busy  out  1  FSM not in RUN
hang  out  1  sticky watchdog error
stall_cycles  out  CW  count of cycles with pc_stall=1

Behaviour:
- Reset: state RUN, mdu_cnt=0, wd_cnt=0, hang=0, stall_cycles=0. All outputs 0 while rst=1.
- FSM states: RUN, MEM_WAIT, MDU_WAIT. Outputs are Mealy: state plus current inputs, same cycle.
- RUN evaluation uses strict priority; only the first true event acts:
  1. exception: flush[3:0]=1111, redirect_sel=2, pc_stall=0; stay RUN.
  2. dcache_miss: pc_stall=1, stall[2:0]=111, flush[3]=1; next MEM_WAIT.
  3. br_mispredict: flush[1:0]=11, redirect_sel=1; stay RUN.
  4. mdu_start: pc_stall=1, stall[1:0]=11, flush[2]=1, mdu_cnt<=MDU_LAT-1; next MDU_WAIT.
  5. load_use: pc_stall=1, stall[0]=1, flush[1]=1, for one cycle; stay RUN.
  6. none: all outputs 0.
- MEM_WAIT:
  - dcache_ready=0: same outputs as RUN priority 2.
  - dcache_ready=1 is the release cycle: evaluate exactly as RUN with exception and dcache_miss forced 0. Next state is RUN, or MDU_WAIT if priority 4 fires.
- MDU_WAIT:
  - mdu_cnt!=0: same outputs as RUN priority 4; mdu_cnt decrements.
  - mdu_cnt==0 is the release cycle: evaluate as RUN with mdu_start forced 0. Next RUN.
  - Total stall cycles for an MDU op = MDU_LAT.
- Events outside the release-cycle evaluation are ignored in wait states; the frozen stages re-present them.
- busy=1 whenever state!=RUN.
- Watchdog: wd_cnt increments each cycle state!=RUN and clears in RUN. When wd_cnt reaches TIMEOUT-1 while busy, hang<=1. hang stays set until reset.
- stall_cycles increments on every cycle with pc_stall=1 and wraps at 2^CW.
- Reset asserted mid-wait aborts immediately to RUN; counters clear.

Decomposition:
- Shared package pipe_pkg: state enum (RUN, MEM_WAIT, MDU_WAIT), redirect_sel encoding constants, register-index constants (R_IFID..R_MEMWB).
- The RUN-priority evaluation goes in one combinational function, reused by the release cycles.
- No sub-module.

Test Plan:
- Load-use only, 1 cycle → pc_stall=1, stall=0001, flush=0010 for exactly 1 cycle, then all 0; stall_cycles=1.
- br_mispredict and load_use in the same cycle → flush=0011, redirect_sel=1, stall=0000.
- dcache_miss, with dcache_ready after 3 cycles → 3 cycles stall=0111, flush=1000, busy=1; release cycle outputs 0; stall_cycles=3.
- MDU_LAT=4, mdu_start held → 4 cycles stall=0011, flush=0100; 5th cycle released with mdu_start still high and ignored; state RUN.
- dcache_miss and exception in the same cycle → flush=1111, redirect_sel=2, state stays RUN. Separately, a miss whose release cycle carries br_mispredict → flush=0011, redirect_sel=1 in the release cycle.
- TIMEOUT=8, dcache_ready never asserted → hang=1 after 8 busy cycles and stays 1 after release; rst pulse clears hang and stall_cycles to 0.
